soc_sysid_checker: RTL and testbench

SOC_SYSID_CHECKER -- requirements
Module: soc_sysid_checker

---
 rtl/soc_sysid_pkg.sv | 20 ++
 rtl/soc_sysid_if.sv | 18 +
 rtl/soc_sysid_timeout.sv | 29 ++
 rtl/soc_sysid_checker.sv | 155 +++++++++++++++
 tb/tb_soc_sysid_checker.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/soc_sysid_pkg.sv
// Shared types and constants for the sysid checker: state encoding, slave word
// addresses and the default expected ID/timestamp words.
package soc_sysid_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REQ_ID  = 3'd1,
      ST_WAIT_ID = 3'd2,
      ST_REQ_TS  = 3'd3,
      ST_WAIT_TS = 3'd4,
      ST_FINISH  = 3'd5
   } sysid_state_e;

   localparam logic        SYSID_ADDR_ID    = 1'b0;
   localparam logic        SYSID_ADDR_TS    = 1'b1;
   localparam logic [31:0] SYSID_EXP_ID_DEF = 32'h0100_0001;
   localparam logic [31:0] SYSID_EXP_TS_DEF = 32'h5819_CCF5;
   localparam int unsigned SYSID_TMO_W      = 16;

endpackage

// File: rtl/soc_sysid_if.sv
// Avalon-MM read-only link between the checker (master) and the sysid slave.
interface soc_sysid_if;
   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        avm_readdatavalid;

   modport master (
      output avm_address, avm_read,
      input  avm_waitrequest, avm_readdata, avm_readdatavalid
   );

   modport slave (
      input  avm_address, avm_read,
      output avm_waitrequest, avm_readdata, avm_readdatavalid
   );
endinterface

// File: rtl/soc_sysid_timeout.sv
// Per-transaction cycle counter: cleared on request entry, counts while a read is
// outstanding, flags expiry on the last allowed cycle.
module soc_sysid_timeout
   import soc_sysid_pkg::*;
#(
   parameter int unsigned LIMIT = 256
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [SYSID_TMO_W-1:0] count;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   assign expired = enable && (count == SYSID_TMO_W'(LIMIT - 1));

endmodule

// File: rtl/soc_sysid_checker.sv
// Reads the sysid ID and timestamp words over Avalon-MM and compares them with
// the expected build values; results and captured words are held until next run.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start (or the one automatic run after reset)
// REQ_ID  | read of word 0 asserted, held while waitrequest is high
// WAIT_ID | ID read accepted, waiting for readdatavalid (USE_RDV only)
// REQ_TS  | read of word 1 asserted, held while waitrequest is high
// WAIT_TS | TS read accepted, waiting for readdatavalid (USE_RDV only)
// FINISH  | one-cycle done pulse, then back to IDLE
module soc_sysid_checker
   import soc_sysid_pkg::*;
#(
   parameter logic [31:0] EXP_ID      = SYSID_EXP_ID_DEF,
   parameter logic [31:0] EXP_TS      = SYSID_EXP_TS_DEF,
   parameter int unsigned TIMEOUT_CYC = 256,
   parameter bit          USE_RDV     = 1'b0,
   parameter bit          AUTO_START  = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   soc_sysid_if.master avm,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   localparam logic [2:0] S_IDLE    = 3'(ST_IDLE);
   localparam logic [2:0] S_REQ_ID  = 3'(ST_REQ_ID);
   localparam logic [2:0] S_WAIT_ID = 3'(ST_WAIT_ID);
   localparam logic [2:0] S_REQ_TS  = 3'(ST_REQ_TS);
   localparam logic [2:0] S_WAIT_TS = 3'(ST_WAIT_TS);
   localparam logic [2:0] S_FINISH  = 3'(ST_FINISH);

   logic [2:0] state;
   logic [2:0] next_state;
   logic       auto_pend;
   logic       read_q;
   logic       addr_q;
   logic       in_req;
   logic       in_xfer;
   logic       accept;
   logic       cap_id;
   logic       cap_ts;
   logic       tmo_exp;
   logic       tmo_hit;
   logic       tmo_clear;
   logic       seq_start;

   assign avm.avm_read    = read_q;
   assign avm.avm_address = addr_q;

   assign in_req  = (state == S_REQ_ID) || (state == S_REQ_TS);
   assign in_xfer = in_req || (state == S_WAIT_ID) || (state == S_WAIT_TS);
   assign accept  = in_req && !avm.avm_waitrequest;

   // Fixed-latency slaves return data with the accept; otherwise only the WAIT
   // states listen to readdatavalid, so stray pulses elsewhere are dropped.
   assign cap_id = USE_RDV ? ((state == S_WAIT_ID) && avm.avm_readdatavalid)
                           : ((state == S_REQ_ID) && accept);
   assign cap_ts = USE_RDV ? ((state == S_WAIT_TS) && avm.avm_readdatavalid)
                           : ((state == S_REQ_TS) && accept);

   assign tmo_hit   = tmo_exp && !cap_id && !cap_ts;
   assign seq_start = (state == S_IDLE) && (next_state == S_REQ_ID);
   assign tmo_clear = ((next_state == S_REQ_ID) && (state != S_REQ_ID)) ||
                      ((next_state == S_REQ_TS) && (state != S_REQ_TS));

   soc_sysid_timeout #(
      .LIMIT (TIMEOUT_CYC)
   ) u_timeout (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (tmo_clear),
      .enable  (in_xfer),
      .expired (tmo_exp)
   );

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (start || auto_pend) next_state = S_REQ_ID;
         end
         S_REQ_ID: begin
            if (cap_id)                next_state = S_REQ_TS;
            else if (tmo_exp)          next_state = S_FINISH;
            else if (accept && USE_RDV) next_state = S_WAIT_ID;
         end
         S_WAIT_ID: begin
            if (cap_id)       next_state = S_REQ_TS;
            else if (tmo_exp) next_state = S_FINISH;
         end
         S_REQ_TS: begin
            if (cap_ts)                next_state = S_FINISH;
            else if (tmo_exp)          next_state = S_FINISH;
            else if (accept && USE_RDV) next_state = S_WAIT_TS;
         end
         S_WAIT_TS: begin
            if (cap_ts || tmo_exp) next_state = S_FINISH;
         end
         S_FINISH: next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   // Avalon strobes and status are registered from next_state so every output
   // is a flop and read drops on the edge that leaves a request state.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         auto_pend <= AUTO_START;
         read_q    <= 1'b0;
         addr_q    <= SYSID_ADDR_ID;
         busy      <= 1'b0;
         done      <= 1'b0;
         id_ok     <= 1'b0;
         ts_ok     <= 1'b0;
         timeout   <= 1'b0;
         id_value  <= '0;
         ts_value  <= '0;
      end else begin
         state     <= next_state;
         auto_pend <= 1'b0;
         read_q    <= (next_state == S_REQ_ID) || (next_state == S_REQ_TS);
         addr_q    <= ((next_state == S_REQ_TS) || (next_state == S_WAIT_TS))
                      ? SYSID_ADDR_TS : SYSID_ADDR_ID;
         busy      <= (next_state != S_IDLE);
         done      <= (next_state == S_FINISH);
         if (seq_start) begin
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
         end
         if (cap_id) begin
            id_value <= avm.avm_readdata;
            id_ok    <= (avm.avm_readdata == EXP_ID);
         end
         if (cap_ts) begin
            ts_value <= avm.avm_readdata;
            ts_ok    <= (avm.avm_readdata == EXP_TS);
         end
         if (tmo_hit) timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_soc_sysid_checker.sv
// Directed bench: fixed-latency checker with auto-start (a) and readdatavalid
// checker with short timeout (b); results scored from per-instance queues.
module tb_soc_sysid_checker;

   localparam logic [31:0] EID = 32'h0100_0001;
   localparam logic [31:0] ETS = 32'h5819_CCF5;

   typedef struct packed {
      logic        iok;
      logic        tok;
      logic        to;
      logic [31:0] iv;
      logic [31:0] tv;
   } exp_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset_n, start_a, start_b;
   logic busy_a, done_a, id_ok_a, ts_ok_a, timeout_a;
   logic busy_b, done_b, id_ok_b, ts_ok_b, timeout_b;
   logic [31:0] id_value_a, ts_value_a, id_value_b, ts_value_b;

   soc_sysid_if if_a ();
   soc_sysid_if if_b ();

   int n_checks = 0;
   int n_fail   = 0;
   int ndone_b  = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   soc_sysid_checker #(.USE_RDV(1'b0), .AUTO_START(1'b1)) dut_a (
      .clock(clock), .reset_n(reset_n), .start(start_a), .avm(if_a),
      .busy(busy_a), .done(done_a), .id_ok(id_ok_a), .ts_ok(ts_ok_a),
      .timeout(timeout_a), .id_value(id_value_a), .ts_value(ts_value_a));

   soc_sysid_checker #(.TIMEOUT_CYC(8), .USE_RDV(1'b1), .AUTO_START(1'b0)) dut_b (
      .clock(clock), .reset_n(reset_n), .start(start_b), .avm(if_b),
      .busy(busy_b), .done(done_b), .id_ok(id_ok_b), .ts_ok(ts_ok_b),
      .timeout(timeout_b), .id_value(id_value_b), .ts_value(ts_value_b));

   // slave a: fixed latency, programmable wait states per read
   logic [31:0] id_word_a, ts_word_a;
   int wait_n_a = 0;
   int wcnt_a   = 0;
   always_comb begin
      if_a.avm_waitrequest   = if_a.avm_read && (wcnt_a < wait_n_a);
      if_a.avm_readdata      = if_a.avm_address ? ts_word_a : id_word_a;
      if_a.avm_readdatavalid = 1'b0;
   end
   always @(posedge clock) begin
      if (if_a.avm_read && if_a.avm_waitrequest) wcnt_a <= wcnt_a + 1;
      else wcnt_a <= 0;
   end

   // slave b: data valid 4 cycles after accept, optional stray valid during TS request
   logic wr_b, stray_b;
   int cd_b = 0;
   logic [31:0] pend_b = '0;
   always_comb begin
      if_b.avm_waitrequest   = wr_b;
      if_b.avm_readdatavalid = (cd_b == 1) || (stray_b && if_b.avm_read && if_b.avm_address);
      if_b.avm_readdata      = (cd_b == 1) ? pend_b : 32'hDEAD_BEEF;
   end
   always @(posedge clock) begin
      if (if_b.avm_read && !wr_b) begin
         cd_b   <= 4;
         pend_b <= if_b.avm_address ? ETS : EID;
      end else if (cd_b != 0) begin
         cd_b <= cd_b - 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic iok, tok, to, input logic [31:0] iv, tv);
      exp_t e;
      e.iok = iok; e.tok = tok; e.to = to; e.iv = iv; e.tv = tv;
      return e;
   endfunction

   task automatic score(input string p, input exp_t e, input logic iok, tok, to,
                        input logic [31:0] iv, tv, input logic rd, bz);
      check({p, "_id_ok"},   iok, e.iok);
      check({p, "_ts_ok"},   tok, e.tok);
      check({p, "_timeout"}, to,  e.to);
      check({p, "_id_value"}, iv, e.iv);
      check({p, "_ts_value"}, tv, e.tv);
      check({p, "_read_in_finish"}, rd, 1'b0);
      check({p, "_busy_in_finish"}, bz, 1'b1);
   endtask

   logic prev_rd_a = 1'b0, prev_wr_a = 1'b0, prev_addr_a = 1'b0;
   always @(negedge clock) begin
      if (reset_n) begin
         if (done_a) begin
            if (q_a.size() == 0) check("a_spurious_done", 1, 0);
            else score("a", q_a.pop_front(), id_ok_a, ts_ok_a, timeout_a,
                       id_value_a, ts_value_a, if_a.avm_read, busy_a);
         end
         if (done_b) begin
            ndone_b++;
            if (q_b.size() == 0) check("b_spurious_done", 1, 0);
            else score("b", q_b.pop_front(), id_ok_b, ts_ok_b, timeout_b,
                       id_value_b, ts_value_b, if_b.avm_read, busy_b);
         end
         if (prev_rd_a && prev_wr_a) begin
            check("a_read_held", if_a.avm_read, 1'b1);
            check("a_addr_held", if_a.avm_address, prev_addr_a);
         end
      end
      prev_rd_a   = reset_n && if_a.avm_read;
      prev_wr_a   = if_a.avm_waitrequest;
      prev_addr_a = if_a.avm_address;
   end

   // Optionally pulses start, then counts falling edges until done is seen.
   task automatic go(input bit b, input int exp_lat, input string tag, input bit do_start);
      int n = 0;
      bit seen = 1'b0;
      if (do_start) begin
         @(negedge clock);
         if (b) start_b = 1'b1; else start_a = 1'b1;
      end
      while (!seen && n < 100) begin
         @(negedge clock);
         n++;
         start_a = 1'b0;
         start_b = 1'b0;
         seen = b ? done_b : done_a;
      end
      check(tag, n, exp_lat);
   endtask

   initial begin
      int n;
      int d0;
      reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
      id_word_a = EID; ts_word_a = ETS; wr_b = 1'b0; stray_b = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_a_busy", busy_a, 0);
      check("rst_a_done", done_a, 0);
      check("rst_a_id_ok", id_ok_a, 0);
      check("rst_a_ts_ok", ts_ok_a, 0);
      check("rst_a_timeout", timeout_a, 0);
      check("rst_a_id_value", id_value_a, 0);
      check("rst_a_ts_value", ts_value_a, 0);
      check("rst_a_read", if_a.avm_read, 0);
      check("rst_a_addr", if_a.avm_address, 0);
      check("rst_b_busy", busy_b, 0);
      check("rst_b_read", if_b.avm_read, 0);

      q_a.push_back(mk(1, 1, 0, EID, ETS));
      reset_n = 1'b1;
      go(0, 3, "a_auto_latency", 0);

      id_word_a = 32'h0100_0002;
      q_a.push_back(mk(0, 1, 0, 32'h0100_0002, ETS));
      go(0, 3, "a_bad_id_latency", 1);

      id_word_a = EID; ts_word_a = 32'h5819_CCF6;
      q_a.push_back(mk(1, 0, 0, EID, 32'h5819_CCF6));
      go(0, 3, "a_bad_ts_latency", 1);

      ts_word_a = ETS; wait_n_a = 5;
      q_a.push_back(mk(1, 1, 0, EID, ETS));
      go(0, 13, "a_wait5_latency", 1);
      wait_n_a = 0;

      stray_b = 1'b1;
      q_b.push_back(mk(1, 1, 0, EID, ETS));
      go(1, 11, "b_rdv_latency", 1);

      wr_b = 1'b1;
      q_b.push_back(mk(0, 0, 1, 32'h0, 32'h0));
      go(1, 9, "b_timeout_latency", 1);
      @(negedge clock);
      check("b_read_after_timeout", if_b.avm_read, 0);
      wr_b = 1'b0;

      // reset while b waits for timestamp data
      start_b = 1'b1;
      @(negedge clock);
      start_b = 1'b0;
      n = 0;
      while (!(busy_b && !if_b.avm_read && if_b.avm_address) && n < 50) begin
         @(negedge clock);
         n++;
      end
      check("b_reached_wait_ts", 32'(n < 50), 1);
      reset_n = 1'b0;
      @(negedge clock);
      check("rst2_b_read", if_b.avm_read, 0);
      check("rst2_b_busy", busy_b, 0);
      repeat (2) @(negedge clock);
      check("rst2_b_done", done_b, 0);
      check("rst2_b_id_ok", id_ok_b, 0);
      check("rst2_b_id_value", id_value_b, 0);
      check("rst2_b_ts_value", ts_value_b, 0);
      check("rst2_b_addr", if_b.avm_address, 0);
      q_a.push_back(mk(1, 1, 0, EID, ETS));
      reset_n = 1'b1;
      go(0, 3, "a_auto_after_reset", 0);
      repeat (8) @(negedge clock);

      // fresh b run with a second start while busy
      d0 = ndone_b;
      q_b.push_back(mk(1, 1, 0, EID, ETS));
      start_b = 1'b1;
      @(negedge clock);
      start_b = 1'b0;
      @(negedge clock);
      start_b = 1'b1;
      @(negedge clock);
      start_b = 1'b0;
      repeat (40) @(negedge clock);
      check("b_single_done", ndone_b - d0, 1);
      check("q_a_drained", q_a.size(), 0);
      check("q_b_drained", q_b.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
